// File: rtl/snn_interfaces_pkg.sv
// Shared types, constants and helpers for the SNN feature-map datapath.
//   fmap_addr_t     : linear address of one feature-map pixel (default geometry)
//   arb_state_t     : ownership FSM states of the feature-map memory arbiter
//   coord_to_addr() : (x, y) -> y*width + x, full 32-bit result; callers truncate
//   DEFAULT_*       : default geometry and word width used across the datapath
package snn_interfaces_pkg;

    localparam int DEFAULT_COORD_BITS = 8;
    localparam int DEFAULT_IMG_WIDTH  = 32;
    localparam int DEFAULT_IMG_HEIGHT = 32;
    localparam int DEFAULT_DATA_BITS  = 64;
    localparam int DEFAULT_ADDR_BITS  = $clog2(DEFAULT_IMG_WIDTH * DEFAULT_IMG_HEIGHT);

    typedef logic [DEFAULT_ADDR_BITS-1:0] fmap_addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;

    function automatic logic [31:0] coord_to_addr(input logic [31:0] x,
                                                  input logic [31:0] y,
                                                  input logic [31:0] img_width);
        return (y * img_width) + x;
    endfunction

endpackage

// File: rtl/fmap_addr_calc.sv
// Coordinate-to-address translation for one memory port (purely combinational).
//   x, y     : pixel coordinate from the currently selected client
//   addr     : y*IMG_WIDTH + x truncated to ADDR_BITS
//   in_range : x < IMG_WIDTH and y < IMG_HEIGHT
module fmap_addr_calc
    import snn_interfaces_pkg::*;
#(
    parameter int COORD_BITS = DEFAULT_COORD_BITS,
    parameter int IMG_WIDTH  = DEFAULT_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEFAULT_IMG_HEIGHT,
    parameter int ADDR_BITS  = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic [COORD_BITS-1:0] x,
    input  logic [COORD_BITS-1:0] y,
    output logic [ADDR_BITS-1:0]  addr,
    output logic                  in_range
);

    assign addr     = ADDR_BITS'(coord_to_addr(32'(x), 32'(y), 32'(IMG_WIDTH)));
    assign in_range = (32'(x) < 32'(IMG_WIDTH)) && (32'(y) < 32'(IMG_HEIGHT));

endmodule

// File: rtl/fmap_mem_arbiter.sv
// Session-based arbiter sharing one simple-dual-port feature-map BRAM between
// the convolution update path (client 0) and the leak/fire sweep (client 1).
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   cN_own_req / cN_own_gnt    : session request (held for the session) / grant
//   cN_rd_req, cN_rd_x/y       : read request and coordinate
//   cN_rd_data, cN_rd_valid    : read return, one cycle after an accepted read
//   cN_wr_req, cN_wr_x/y/data  : write request, coordinate and data
//   bram_rd_*, bram_wr_*       : BRAM ports (read: 1-cycle latency, read-first)
//   coord_err                  : sticky out-of-range coordinate flag
//   state_dbg                  : current arbiter state (arb_state_t encoding)
// Handshake: a request is accepted in the cycle it is presented, provided the
// client owns the memory (gnt high) and still holds own_req; there is no
// backpressure. Accepted reads always return exactly one cycle later.
module fmap_mem_arbiter
    import snn_interfaces_pkg::*;
#(
    parameter int COORD_BITS = DEFAULT_COORD_BITS,
    parameter int IMG_WIDTH  = DEFAULT_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEFAULT_IMG_HEIGHT,
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int ADDR_BITS  = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  c0_own_req,
    output logic                  c0_own_gnt,
    input  logic                  c0_rd_req,
    input  logic [COORD_BITS-1:0] c0_rd_x,
    input  logic [COORD_BITS-1:0] c0_rd_y,
    output logic [DATA_BITS-1:0]  c0_rd_data,
    output logic                  c0_rd_valid,
    input  logic                  c0_wr_req,
    input  logic [COORD_BITS-1:0] c0_wr_x,
    input  logic [COORD_BITS-1:0] c0_wr_y,
    input  logic [DATA_BITS-1:0]  c0_wr_data,

    input  logic                  c1_own_req,
    output logic                  c1_own_gnt,
    input  logic                  c1_rd_req,
    input  logic [COORD_BITS-1:0] c1_rd_x,
    input  logic [COORD_BITS-1:0] c1_rd_y,
    output logic [DATA_BITS-1:0]  c1_rd_data,
    output logic                  c1_rd_valid,
    input  logic                  c1_wr_req,
    input  logic [COORD_BITS-1:0] c1_wr_x,
    input  logic [COORD_BITS-1:0] c1_wr_y,
    input  logic [DATA_BITS-1:0]  c1_wr_data,

    output logic                  bram_rd_en,
    output logic [ADDR_BITS-1:0]  bram_rd_addr,
    input  logic [DATA_BITS-1:0]  bram_rd_data,
    output logic                  bram_wr_en,
    output logic [ADDR_BITS-1:0]  bram_wr_addr,
    output logic [DATA_BITS-1:0]  bram_wr_data,

    output logic                  coord_err,
    output logic [1:0]            state_dbg
);

    // ------------------------------------------------------------------
    // Ownership FSM
    // ------------------------------------------------------------------
    arb_state_t state_q, state_d;
    logic       rr_ptr_q, rr_ptr_d;   // 0: c0 wins a tie in IDLE, 1: c1 wins
    logic       owner_q, owner_d;     // current / most recent owner

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= 1'b0;
            owner_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        case (state_q)
            IDLE: begin
                if (c0_own_req && (!c1_own_req || !rr_ptr_q)) begin
                    state_d = OWN0;
                    owner_d = 1'b0;
                end else if (c1_own_req) begin
                    state_d = OWN1;
                    owner_d = 1'b1;
                end
            end
            OWN0: if (!c0_own_req) state_d = DRAIN;
            OWN1: if (!c1_own_req) state_d = DRAIN;
            DRAIN: begin
                // Priority moves to the client that did not just own the memory,
                // and that client is handed the memory directly if it is waiting.
                rr_ptr_d = ~owner_q;
                if (owner_q ? c0_own_req : c1_own_req) begin
                    state_d = owner_q ? OWN0 : OWN1;
                    owner_d = ~owner_q;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign c0_own_gnt = (state_q == OWN0);
    assign c1_own_gnt = (state_q == OWN1);
    assign state_dbg  = state_q;

    // ------------------------------------------------------------------
    // Client mux and address translation
    // ------------------------------------------------------------------
    logic                  sel_c1;
    logic                  owner_active;
    logic                  rd_fwd, wr_fwd;
    logic [COORD_BITS-1:0] rd_x_m, rd_y_m, wr_x_m, wr_y_m;
    logic [DATA_BITS-1:0]  wr_data_m;
    logic [ADDR_BITS-1:0]  rd_addr, wr_addr;
    logic                  rd_in_range, wr_in_range;

    assign sel_c1       = (state_q == OWN1);
    // A client that drops own_req loses forwarding at once, even though its
    // registered grant is still high for that cycle.
    assign owner_active = ((state_q == OWN0) && c0_own_req) ||
                          ((state_q == OWN1) && c1_own_req);

    assign rd_fwd    = owner_active && (sel_c1 ? c1_rd_req : c0_rd_req);
    assign wr_fwd    = owner_active && (sel_c1 ? c1_wr_req : c0_wr_req);
    assign rd_x_m    = sel_c1 ? c1_rd_x : c0_rd_x;
    assign rd_y_m    = sel_c1 ? c1_rd_y : c0_rd_y;
    assign wr_x_m    = sel_c1 ? c1_wr_x : c0_wr_x;
    assign wr_y_m    = sel_c1 ? c1_wr_y : c0_wr_y;
    assign wr_data_m = sel_c1 ? c1_wr_data : c0_wr_data;

    fmap_addr_calc #(
        .COORD_BITS (COORD_BITS),
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT),
        .ADDR_BITS  (ADDR_BITS)
    ) u_rd_addr (
        .x        (rd_x_m),
        .y        (rd_y_m),
        .addr     (rd_addr),
        .in_range (rd_in_range)
    );

    fmap_addr_calc #(
        .COORD_BITS (COORD_BITS),
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT),
        .ADDR_BITS  (ADDR_BITS)
    ) u_wr_addr (
        .x        (wr_x_m),
        .y        (wr_y_m),
        .addr     (wr_addr),
        .in_range (wr_in_range)
    );

    // Address/data buses are held at zero whenever the port is not enabled.
    assign bram_rd_en   = rd_fwd && rd_in_range;
    assign bram_rd_addr = bram_rd_en ? rd_addr : '0;
    assign bram_wr_en   = wr_fwd && wr_in_range;
    assign bram_wr_addr = bram_wr_en ? wr_addr : '0;
    assign bram_wr_data = bram_wr_en ? wr_data_m : '0;

    // ------------------------------------------------------------------
    // Read return pipeline, same-address bypass and error flag
    // ------------------------------------------------------------------
    logic                 rd_pend_q, rd_pend_d;
    logic                 rd_client_q, rd_client_d;
    logic                 rd_zero_q, rd_zero_d;
    logic                 byp_hit_q, byp_hit_d;
    logic [DATA_BITS-1:0] byp_data_q, byp_data_d;
    logic                 coord_err_q, coord_err_d;
    logic [DATA_BITS-1:0] ret_data;

    always_comb begin
        rd_pend_d   = rd_fwd;
        rd_client_d = sel_c1;
        rd_zero_d   = !rd_in_range;
        // The BRAM is read-first, so a same-cycle write to the read address
        // would otherwise return the stale word.
        byp_hit_d   = bram_rd_en && bram_wr_en && (rd_addr == wr_addr);
        byp_data_d  = byp_hit_d ? wr_data_m : byp_data_q;
        coord_err_d = coord_err_q ||
                      (rd_fwd && !rd_in_range) ||
                      (wr_fwd && !wr_in_range);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q   <= 1'b0;
            rd_client_q <= 1'b0;
            rd_zero_q   <= 1'b0;
            byp_hit_q   <= 1'b0;
            byp_data_q  <= '0;
            coord_err_q <= 1'b0;
        end else begin
            rd_pend_q   <= rd_pend_d;
            rd_client_q <= rd_client_d;
            rd_zero_q   <= rd_zero_d;
            byp_hit_q   <= byp_hit_d;
            byp_data_q  <= byp_data_d;
            coord_err_q <= coord_err_d;
        end
    end

    always_comb begin
        ret_data = '0;
        if (rd_pend_q && !rd_zero_q) begin
            ret_data = byp_hit_q ? byp_data_q : bram_rd_data;
        end
    end

    assign c0_rd_valid = rd_pend_q && !rd_client_q;
    assign c1_rd_valid = rd_pend_q &&  rd_client_q;
    assign c0_rd_data  = c0_rd_valid ? ret_data : '0;
    assign c1_rd_data  = c1_rd_valid ? ret_data : '0;
    assign coord_err   = coord_err_q;

endmodule

// File: tb/tb_fmap_mem_arbiter.sv
module tb_fmap_mem_arbiter;
  import snn_interfaces_pkg::*;

  localparam int CB = 8;
  localparam int DB = 64;
  localparam int AB = 10;

  logic          clk;
  logic          rst_n;
  logic          c0_own_req, c0_own_gnt, c0_rd_req, c0_rd_valid, c0_wr_req;
  logic [CB-1:0] c0_rd_x, c0_rd_y, c0_wr_x, c0_wr_y;
  logic [DB-1:0] c0_rd_data, c0_wr_data;
  logic          c1_own_req, c1_own_gnt, c1_rd_req, c1_rd_valid, c1_wr_req;
  logic [CB-1:0] c1_rd_x, c1_rd_y, c1_wr_x, c1_wr_y;
  logic [DB-1:0] c1_rd_data, c1_wr_data;
  logic          bram_rd_en, bram_wr_en;
  logic [AB-1:0] bram_rd_addr, bram_wr_addr;
  logic [DB-1:0] bram_rd_data, bram_wr_data;
  logic          coord_err;
  logic [1:0]    state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DB-1:0] mem [0:1023];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- BRAM model: 1-cycle latency, read-first ----------------
  always @(posedge clk) begin
    if (bram_rd_en) bram_rd_data <= mem[bram_rd_addr];
    if (bram_wr_en) mem[bram_wr_addr] <= bram_wr_data;
  end

  fmap_mem_arbiter #(
    .COORD_BITS(CB), .IMG_WIDTH(32), .IMG_HEIGHT(32), .DATA_BITS(DB), .ADDR_BITS(AB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .c0_own_req(c0_own_req), .c0_own_gnt(c0_own_gnt),
    .c0_rd_req(c0_rd_req), .c0_rd_x(c0_rd_x), .c0_rd_y(c0_rd_y),
    .c0_rd_data(c0_rd_data), .c0_rd_valid(c0_rd_valid),
    .c0_wr_req(c0_wr_req), .c0_wr_x(c0_wr_x), .c0_wr_y(c0_wr_y), .c0_wr_data(c0_wr_data),
    .c1_own_req(c1_own_req), .c1_own_gnt(c1_own_gnt),
    .c1_rd_req(c1_rd_req), .c1_rd_x(c1_rd_x), .c1_rd_y(c1_rd_y),
    .c1_rd_data(c1_rd_data), .c1_rd_valid(c1_rd_valid),
    .c1_wr_req(c1_wr_req), .c1_wr_x(c1_wr_x), .c1_wr_y(c1_wr_y), .c1_wr_data(c1_wr_data),
    .bram_rd_en(bram_rd_en), .bram_rd_addr(bram_rd_addr), .bram_rd_data(bram_rd_data),
    .bram_wr_en(bram_wr_en), .bram_wr_addr(bram_wr_addr), .bram_wr_data(bram_wr_data),
    .coord_err(coord_err), .state_dbg(state_dbg)
  );

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    c0_own_req = 0; c0_rd_req = 0; c0_rd_x = 0; c0_rd_y = 0;
    c0_wr_req = 0; c0_wr_x = 0; c0_wr_y = 0; c0_wr_data = 0;
    c1_own_req = 0; c1_rd_req = 0; c1_rd_x = 0; c1_rd_y = 0;
    c1_wr_req = 0; c1_wr_x = 0; c1_wr_y = 0; c1_wr_data = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #12;
    n_checks++; if (c0_own_gnt !== 1'b0 || c1_own_gnt !== 1'b0) begin n_fail++;
      $display("FAIL reset_gnt: got %b%b want 00", c0_own_gnt, c1_own_gnt); end
    n_checks++; if (c0_rd_valid !== 1'b0 || c1_rd_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_rd_valid: got %b%b want 00", c0_rd_valid, c1_rd_valid); end
    n_checks++; if (bram_rd_en !== 1'b0 || bram_wr_en !== 1'b0 || coord_err !== 1'b0) begin n_fail++;
      $display("FAIL reset_en_err: got rd_en=%b wr_en=%b err=%b want 0", bram_rd_en, bram_wr_en, coord_err); end
    n_checks++; if (bram_rd_addr !== '0 || bram_wr_addr !== '0 || bram_wr_data !== '0 ||
                    c0_rd_data !== '0 || c1_rd_data !== '0) begin n_fail++;
      $display("FAIL reset_buses: got rd_addr=%0d wr_addr=%0d wr_data=%h want 0", bram_rd_addr, bram_wr_addr, bram_wr_data); end
    n_checks++; if (state_dbg !== 2'd0) begin n_fail++;
      $display("FAIL reset_state: got %0d want 0", state_dbg); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_basic_read();
    @(negedge clk);
    c0_own_req = 1;
    #1;
    n_checks++; if (c0_own_gnt !== 1'b0) begin n_fail++;
      $display("FAIL basic_gnt_early: got %b want 0", c0_own_gnt); end
    @(negedge clk);
    c0_rd_req = 1; c0_rd_x = 3; c0_rd_y = 2;
    #1;
    n_checks++; if (c0_own_gnt !== 1'b1 || c1_own_gnt !== 1'b0) begin n_fail++;
      $display("FAIL basic_gnt: got %b%b want 10", c0_own_gnt, c1_own_gnt); end
    n_checks++; if (bram_rd_en !== 1'b1 || bram_rd_addr !== 10'd67) begin n_fail++;
      $display("FAIL basic_rd_addr: got en=%b addr=%0d want en=1 addr=67", bram_rd_en, bram_rd_addr); end
    @(negedge clk);
    c0_rd_req = 0;
    #1;
    n_checks++; if (c0_rd_valid !== 1'b1 || c0_rd_data !== 64'h0123_4567_89AB_CDEF) begin n_fail++;
      $display("FAIL basic_rd_data: got v=%b d=%h want v=1 d=0123456789abcdef", c0_rd_valid, c0_rd_data); end
    n_checks++; if (c1_rd_valid !== 1'b0 || c1_rd_data !== '0) begin n_fail++;
      $display("FAIL basic_c1_quiet: got v=%b d=%h want 0", c1_rd_valid, c1_rd_data); end
    @(negedge clk);
    #1;
    n_checks++; if (c0_rd_valid !== 1'b0 || c0_rd_data !== '0) begin n_fail++;
      $display("FAIL basic_rd_one_shot: got v=%b d=%h want 0", c0_rd_valid, c0_rd_data); end
    c0_own_req = 0;
  endtask

  task automatic test_round_robin();
    pulse_reset();
    @(negedge clk);
    c0_own_req = 1; c1_own_req = 1;
    @(negedge clk); #1;
    n_checks++; if (c0_own_gnt !== 1'b1 || c1_own_gnt !== 1'b0) begin n_fail++;
      $display("FAIL rr_first_tie: got %b%b want 10", c0_own_gnt, c1_own_gnt); end
    c0_own_req = 0;
    @(negedge clk); #1;
    n_checks++; if (c0_own_gnt !== 1'b0 || c1_own_gnt !== 1'b0 || state_dbg !== 2'd3) begin n_fail++;
      $display("FAIL rr_drain: got gnt=%b%b state=%0d want 00 state=3", c0_own_gnt, c1_own_gnt, state_dbg); end
    @(negedge clk); #1;
    n_checks++; if (c1_own_gnt !== 1'b1 || c0_own_gnt !== 1'b0) begin n_fail++;
      $display("FAIL rr_handover_c1: got %b%b want 01", c0_own_gnt, c1_own_gnt); end
    c1_own_req = 0; c0_own_req = 1;
    @(negedge clk);
    @(negedge clk); #1;
    n_checks++; if (c0_own_gnt !== 1'b1 || c1_own_gnt !== 1'b0) begin n_fail++;
      $display("FAIL rr_handover_c0: got %b%b want 10", c0_own_gnt, c1_own_gnt); end
    c0_own_req = 0;
    @(negedge clk);
    @(negedge clk); #1;
    n_checks++; if (state_dbg !== 2'd0) begin n_fail++;
      $display("FAIL rr_idle: got state=%0d want 0", state_dbg); end
    c0_own_req = 1; c1_own_req = 1;
    @(negedge clk); #1;
    n_checks++; if (c1_own_gnt !== 1'b1 || c0_own_gnt !== 1'b0) begin n_fail++;
      $display("FAIL rr_second_tie: got %b%b want 01", c0_own_gnt, c1_own_gnt); end
    c0_own_req = 0; c1_own_req = 0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_hazard();
    @(negedge clk);
    c0_own_req = 1;
    @(negedge clk);
    c0_rd_req = 1; c0_rd_x = 5; c0_rd_y = 5;
    c0_wr_req = 1; c0_wr_x = 5; c0_wr_y = 5; c0_wr_data = 64'hABCD;
    #1;
    n_checks++; if (c0_own_gnt !== 1'b1) begin n_fail++;
      $display("FAIL hz_gnt: got %b want 1", c0_own_gnt); end
    n_checks++; if (bram_rd_en !== 1'b1 || bram_wr_en !== 1'b1 || bram_rd_addr !== 10'd165 ||
                    bram_wr_addr !== 10'd165 || bram_wr_data !== 64'hABCD) begin n_fail++;
      $display("FAIL hz_issue: got rd=%b@%0d wr=%b@%0d d=%h want both @165 d=abcd",
               bram_rd_en, bram_rd_addr, bram_wr_en, bram_wr_addr, bram_wr_data); end
    @(negedge clk);
    c0_rd_req = 0; c0_wr_req = 0;
    #1;
    n_checks++; if (c0_rd_valid !== 1'b1 || c0_rd_data !== 64'hABCD) begin n_fail++;
      $display("FAIL hz_bypass: got v=%b d=%h want v=1 d=abcd", c0_rd_valid, c0_rd_data); end
    n_checks++; if (mem[165] !== 64'hABCD) begin n_fail++;
      $display("FAIL hz_mem_write: got %h want abcd", mem[165]); end
    c0_rd_req = 1;
    @(negedge clk);
    c0_rd_req = 0;
    #1;
    n_checks++; if (c0_rd_valid !== 1'b1 || c0_rd_data !== 64'hABCD) begin n_fail++;
      $display("FAIL hz_reread: got v=%b d=%h want v=1 d=abcd", c0_rd_valid, c0_rd_data); end
  endtask

  task automatic test_range_check();
    @(negedge clk);
    c0_rd_req = 1; c0_rd_x = 32; c0_rd_y = 0;
    #1;
    n_checks++; if (bram_rd_en !== 1'b0 || coord_err !== 1'b0) begin n_fail++;
      $display("FAIL oor_rd_suppress: got en=%b err=%b want 0 0", bram_rd_en, coord_err); end
    @(negedge clk);
    c0_rd_req = 0;
    c0_wr_req = 1; c0_wr_x = 0; c0_wr_y = 40; c0_wr_data = 64'hFFFF;
    #1;
    n_checks++; if (c0_rd_valid !== 1'b1 || c0_rd_data !== '0 || coord_err !== 1'b1) begin n_fail++;
      $display("FAIL oor_rd_return: got v=%b d=%h err=%b want 1 0 1", c0_rd_valid, c0_rd_data, coord_err); end
    n_checks++; if (bram_wr_en !== 1'b0 || bram_wr_data !== '0) begin n_fail++;
      $display("FAIL oor_wr_suppress: got en=%b d=%h want 0 0", bram_wr_en, bram_wr_data); end
    @(negedge clk);
    c0_wr_req = 0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (coord_err !== 1'b1) begin n_fail++;
      $display("FAIL oor_sticky: got %b want 1", coord_err); end
  endtask

  task automatic test_non_owner();
    @(negedge clk);
    c1_rd_req = 1; c1_rd_x = 1; c1_rd_y = 1;
    c1_wr_req = 1; c1_wr_x = 1; c1_wr_y = 1; c1_wr_data = 64'hDEAD;
    #1;
    n_checks++; if (bram_rd_en !== 1'b0 || bram_wr_en !== 1'b0 || c1_own_gnt !== 1'b0) begin n_fail++;
      $display("FAIL nonown_enables: got rd=%b wr=%b gnt1=%b want 0 0 0", bram_rd_en, bram_wr_en, c1_own_gnt); end
    @(negedge clk);
    c1_rd_req = 0; c1_wr_req = 0;
    #1;
    n_checks++; if (c1_rd_valid !== 1'b0 || c1_rd_data !== '0 || c0_rd_valid !== 1'b0) begin n_fail++;
      $display("FAIL nonown_no_return: got v1=%b d1=%h v0=%b want 0", c1_rd_valid, c1_rd_data, c0_rd_valid); end
    n_checks++; if (mem[33] !== 64'h5555) begin n_fail++;
      $display("FAIL nonown_mem: got %h want 5555", mem[33]); end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    c0_rd_req = 1; c0_rd_x = 0; c0_rd_y = 0;
    @(posedge clk);
    #2;
    n_checks++; if (c0_rd_valid !== 1'b1 || c0_own_gnt !== 1'b1 || coord_err !== 1'b1) begin n_fail++;
      $display("FAIL midrst_pre: got v=%b gnt=%b err=%b want 1 1 1", c0_rd_valid, c0_own_gnt, coord_err); end
    rst_n = 0;
    #1;
    n_checks++; if (c0_own_gnt !== 1'b0 || c0_rd_valid !== 1'b0 || c0_rd_data !== '0) begin n_fail++;
      $display("FAIL midrst_clear: got gnt=%b v=%b d=%h want 0", c0_own_gnt, c0_rd_valid, c0_rd_data); end
    n_checks++; if (bram_rd_en !== 1'b0 || bram_wr_en !== 1'b0 || state_dbg !== 2'd0 || coord_err !== 1'b0) begin n_fail++;
      $display("FAIL midrst_state: got rd=%b wr=%b state=%0d err=%b want 0", bram_rd_en, bram_wr_en, state_dbg, coord_err); end
    clear_inputs();
    c1_own_req = 1;
    @(negedge clk);
    rst_n = 1;
    #1;
    n_checks++; if (c1_own_gnt !== 1'b0) begin n_fail++;
      $display("FAIL midrst_gnt_early: got %b want 0", c1_own_gnt); end
    @(negedge clk); #1;
    n_checks++; if (c1_own_gnt !== 1'b1 || state_dbg !== 2'd2) begin n_fail++;
      $display("FAIL midrst_regrant: got gnt1=%b state=%0d want 1 2", c1_own_gnt, state_dbg); end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[67]  = 64'h0123_4567_89AB_CDEF;
    mem[165] = 64'h1111;
    mem[33]  = 64'h5555;
    bram_rd_data = '0;
    rst_n = 0;
    clear_inputs();

    test_reset();
    test_basic_read();
    test_round_robin();
    test_hazard();
    test_range_check();
    test_non_owner();
    test_reset_mid_op();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fmap_mem_arbiter.md
Name: fmap_mem_arbiter

Overview:
Shares one simple-dual-port feature-map BRAM (neuron state) between two clients. Client 0 is the event-driven 2D convolution update path. Client 1 is the timestep leak/fire sweep. Ownership is granted per session, so a client's read-modify-write burst is never interleaved with the other client. Translates (x,y) coordinates to linear addresses, range-checks them, and resolves same-cycle read/write hazards.

Parameters:
COORD_BITS, 8, width of x and y coordinates
IMG_WIDTH, 32, feature-map width
IMG_HEIGHT, 32, feature-map height
DATA_BITS, 64, BRAM word width (all output channels of one pixel)
ADDR_BITS, $clog2(IMG_WIDTH*IMG_HEIGHT), BRAM address width (derived)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
cN_own_req  in  1  (N=0,1) session request; held high for the whole session
cN_own_gnt  out  1  session granted to client N
cN_rd_req  in  1  read request
cN_rd_x, cN_rd_y  in  COORD_BITS  read coordinate
cN_rd_data  out  DATA_BITS  read data
cN_rd_valid  out  1  read data valid
cN_wr_req  in  1  write request
cN_wr_x, cN_wr_y  in  COORD_BITS  write coordinate
cN_wr_data  in  DATA_BITS  write data
bram_rd_en  out  1  BRAM read enable
bram_rd_addr  out  ADDR_BITS  BRAM read address
bram_rd_data  in  DATA_BITS  BRAM read data; 1-cycle latency, read-first
bram_wr_en  out  1  BRAM write enable
bram_wr_addr  out  ADDR_BITS  BRAM write address
bram_wr_data  out  DATA_BITS  BRAM write data
coord_err  out  1  sticky out-of-range flag

Behaviour:
- Reset values:
  - state IDLE; rr_ptr selects c0.
  - All gnt, rd_valid, bram enables and coord_err are 0.
  - All address and data outputs are 0.
- States:
  - IDLE.
  - OWN0, OWN1: registered gnt high only for the owner.
  - DRAIN: one cycle, no grant. Returns any in-flight read, then flips rr_ptr to the non-previous owner.
- IDLE: if any own_req is high, grant the requester. When both request, rr_ptr decides. gnt rises the cycle after own_req is sampled.
- OWNn -> DRAIN when cn_own_req is sampled low. DRAIN -> OWN(other) if the other client is requesting, otherwise IDLE. Handover: release at t, other client's gnt at t+2.
- Forwarding:
  - Only the owner's rd_req and wr_req are forwarded, and only while own_req and gnt are both high. All other requests are ignored silently; no rd_valid results.
  - Forwarding is combinational in the same cycle: addr = y*IMG_WIDTH + x, truncated to ADDR_BITS.
  - One read and one write may be issued per cycle.
- Read return: cn_rd_valid and cn_rd_data follow exactly 1 cycle after an accepted rd_req. This holds also when the accept happens in the last owned cycle, since DRAIN returns it. rd_data is 0 whenever rd_valid is low.
- Hazard: an accepted read and write to the same address in the same cycle returns that cycle's wr_data (bypass register), not the stale BRAM word. A write at t followed by a read at t+1 needs no bypass.
- Range check: x >= IMG_WIDTH or y >= IMG_HEIGHT:
  - The corresponding bram enable is suppressed and coord_err is set (sticky until reset).
  - For a read, rd_valid is still returned with data 0, which keeps the client's pipeline aligned.
- Reset mid-operation: all outputs clear immediately (asynchronous). In-flight read data is discarded.
- Ownership is unbounded; clients must release between bursts. Round-robin then guarantees alternation under contention.

Decomposition:
- snn_interfaces_pkg gains:
  - fmap_addr_t
  - arb_state_t (IDLE, OWN0, OWN1, DRAIN)
  - function coord_to_addr
  - the DEFAULT_* constants reused here
- Sub-module fmap_addr_calc: coordinate to {addr, in_range}, purely combinational. Instantiated twice, once for the read path and once for the write path, after client muxing.

Test Plan:
1. After reset, c0_own_req=1 at cycle 0 -> c0_own_gnt=1 at cycle 1; c0 reads (3,2) with IMG_WIDTH=32 -> bram_rd_addr=67 same cycle; c0_rd_valid and c0_rd_data equal bram_rd_data next cycle.
2. Both own_req rise together -> c0 granted. c0 releases at t -> c1_own_gnt at t+2. c1 releases with c0 still requesting -> c0 granted. Repeat contention with both requesting from IDLE -> c1 granted (rr_ptr alternates).
3. Owner reads and writes (5,5) in the same cycle with wr_data=0xABCD, BRAM holding 0x1111 -> rd_data=0xABCD; a subsequent read returns 0xABCD from the BRAM.
4. Owner reads (32,0) -> bram_rd_en=0; rd_valid=1 with data 0 next cycle; coord_err=1 and stays high until rst_n low.
5. c1 asserts rd_req and wr_req at (1,1) while c0 owns -> no bram enables from c1, c1_rd_valid stays 0, memory contents unchanged.
6. rst_n pulsed low while a read is in flight and gnt=1 -> gnt, rd_valid and bram enables go 0 immediately; state IDLE; a fresh c1 request is then granted after one cycle.
